// File: rtl/clock_meter.sv
// Measures period and high time of a slow asynchronous signal in clk cycles, with lock and stall detection.
// Optional min/max period tracking is enabled by defining CLOCK_METER_MINMAX_EN.
module clock_meter #(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2**20
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
`ifdef CLOCK_METER_MINMAX_EN
    ,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;
    logic                   sync_q;
    logic                   rise;
    logic                   fall;

    state_t                 state_reg;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   at_limit;

    logic [CNT_W-1:0]       period_reg;
    logic [CNT_W-1:0]       high_time_reg;
    logic [CNT_W-1:0]       prev_period_reg;
    logic                   valid_reg;
    logic                   locked_reg;
    logic                   timeout_reg;
    logic                   first_reg;

    logic                   take_period;
    logic                   take_high;
    logic                   stall;

    // Input synchroniser followed by one history flop for edge detection
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign sync_q   = sync_reg[SYNC_STAGES-1];
    assign rise     = sync_q & ~hist_reg;
    assign fall     = ~sync_q & hist_reg;
    assign at_limit = (cnt_reg == TIMEOUT_C);
    assign cnt_inc  = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_ARM;
                ST_ARM:  if (rise) state_next = ST_MEAS;
                ST_MEAS: if (!rise && at_limit) state_next = ST_ARM;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // A rise always beats the stall compare; a disabled block ignores both
    always_comb begin
        take_period = 1'b0;
        take_high   = 1'b0;
        stall       = 1'b0;
        cnt_next    = cnt_reg;
        if (!enable || state_reg == ST_IDLE) begin
            cnt_next = '0;
        end else if (rise) begin
            take_period = (state_reg == ST_MEAS);
            cnt_next    = CNT_ONE;
        end else if (at_limit) begin
            stall    = 1'b1;
            cnt_next = '0;
        end else begin
            take_high = (state_reg == ST_MEAS) && fall;
            cnt_next  = cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_reg         <= '0;
            period_reg      <= '0;
            high_time_reg   <= '0;
            prev_period_reg <= '0;
            valid_reg       <= 1'b0;
            locked_reg      <= 1'b0;
            timeout_reg     <= 1'b0;
            first_reg       <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            valid_reg <= take_period;
            if (take_period) begin
                period_reg      <= cnt_reg;
                prev_period_reg <= cnt_reg;
                timeout_reg     <= 1'b0;
                locked_reg      <= !first_reg && (cnt_reg == prev_period_reg);
                first_reg       <= 1'b0;
            end
            if (take_high) begin
                high_time_reg <= cnt_reg;
            end
            if (stall) begin
                timeout_reg <= 1'b1;
                locked_reg  <= 1'b0;
            end
            // The edge that leaves ARM only sets phase; its first period cannot lock
            if (enable && state_reg == ST_ARM && rise) begin
                first_reg <= 1'b1;
            end
            if (!enable) begin
                locked_reg <= 1'b0;
            end
        end
    end

    assign period    = period_reg;
    assign high_time = high_time_reg;
    assign valid     = valid_reg;
    assign locked    = locked_reg;
    assign timeout   = timeout_reg;

`ifdef CLOCK_METER_MINMAX_EN
    logic             en_d_reg;
    logic [CNT_W-1:0] min_reg;
    logic [CNT_W-1:0] max_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            en_d_reg <= 1'b0;
            min_reg  <= '1;
            max_reg  <= '0;
        end else begin
            en_d_reg <= enable;
            if (enable && !en_d_reg) begin
                min_reg <= '1;
                max_reg <= '0;
            end else if (take_period) begin
                if (cnt_reg < min_reg) min_reg <= cnt_reg;
                if (cnt_reg > max_reg) max_reg <= cnt_reg;
            end
        end
    end

    assign min_period = min_reg;
    assign max_period = max_reg;
`endif

endmodule
